axil_mem_tester: RTL and testbench



---
 rtl/memtest_pkg.sv | 27 ++
 rtl/taxi_axil_if.sv | 43 ++++
 rtl/memtest_lfsr.sv | 25 ++
 rtl/axil_mem_tester.sv | 220 ++++++++++++++++++++++
 tb/tb_axil_mem_tester.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memtest_pkg.sv
// Shared definitions for the AXI-Lite memory tester: FSM state encoding,
// AXI response codes and the Galois LFSR step used by both test phases.
package memtest_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdResp,
    StDone
  } state_e;

  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlverr = 2'b10;
  localparam logic [31:0] LfsrTaps   = 32'h8020_0003;

  // One right-shift Galois step; a nonzero state never maps to zero because
  // a shifted-out 1 always sets bit 31 through the taps.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ LfsrTaps;
    return n;
  endfunction

endpackage

// File: rtl/taxi_axil_if.sv
// AXI-Lite interface bundle.
// Modports: man (manager drives aw/w/ar channels and b/r readies),
//           sub (subordinate drives the opposite directions).
interface taxi_axil_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport man (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport sub (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/memtest_lfsr.sv
// Pattern generator for the memory tester.
// Ports: clk, rst (async active-low), load (value <= seed, has priority),
//        advance (value <= next Galois step), seed, value (registered state).
module memtest_lfsr import memtest_pkg::*; #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= RESET_VAL;
    end else if (load) begin
      value <= seed;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/axil_mem_tester.sv
// AXI-Lite master that writes an LFSR pattern over a word window, reads it
// back and compares. One transaction outstanding at any time.
// Ports: clk, rst (async active-low), axi_if (AXI-Lite manager), start,
//        busy, done, pass, err_count (saturating), first_err_addr, timeout.
// Optional: define MEMTEST_TIMEOUT_EN to enable the stall watchdog
//           (TIMEOUT_CYC cycles without progress forces DONE with timeout=1).
module axil_mem_tester import memtest_pkg::*; #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned NUM_WORDS   = 1024,
  parameter logic [31:0] SEED        = 32'hACE1_2468,
  parameter int unsigned ERR_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  taxi_axil_if.man         axi_if,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      first_err_addr,
  output logic             timeout
);

  state_e      state;
  logic [31:0] addr, idx, lfsr;
  logic        aw_done, w_done, err_seen;
  logic        aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
  logic        last, start_ok, lfsr_load, lfsr_adv, beat_err, tmo_fire;

  assign axi_if.awprot = 3'b000;
  assign axi_if.arprot = 3'b000;

  always_comb begin
    aw_hs     = axi_if.awvalid & axi_if.awready;
    w_hs      = axi_if.wvalid & axi_if.wready;
    b_hs      = (state == StWrResp) & axi_if.bvalid & axi_if.bready;
    ar_hs     = axi_if.arvalid & axi_if.arready;
    r_hs      = (state == StRdResp) & axi_if.rvalid & axi_if.rready;
    any_hs    = aw_hs | w_hs | b_hs | ar_hs | r_hs;
    last      = (idx == 32'(NUM_WORDS - 1));
    start_ok  = ((state == StIdle) | (state == StDone)) & start;
    // Reseed when the write phase finishes so the read phase regenerates it.
    lfsr_load = start_ok | (b_hs & last);
    lfsr_adv  = (b_hs & ~last) | r_hs;
    beat_err  = (b_hs & (axi_if.bresp != RespOkay)) |
                (r_hs & ((axi_if.rdata != lfsr) | (axi_if.rresp != RespOkay)));
  end

  memtest_lfsr #(
    .RESET_VAL(SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (lfsr_load),
    .advance(lfsr_adv),
    .seed   (SEED),
    .value  (lfsr)
  );

`ifdef MEMTEST_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        active;

  // Every state change coincides with a handshake or an accepted start,
  // so clearing on those also clears on state changes.
  assign active   = (state == StWrReq) | (state == StWrResp) |
                    (state == StRdReq) | (state == StRdResp);
  assign tmo_fire = active & ~any_hs & (tmo_cnt == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (!active || any_hs || tmo_fire) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC ^ any_hs;
  assign tmo_fire   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= StIdle;
      addr           <= '0;
      idx            <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      err_seen       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      axi_if.awvalid <= 1'b0;
      axi_if.awaddr  <= '0;
      axi_if.wvalid  <= 1'b0;
      axi_if.wdata   <= '0;
      axi_if.wstrb   <= '0;
      axi_if.bready  <= 1'b0;
      axi_if.arvalid <= 1'b0;
      axi_if.araddr  <= '0;
      axi_if.rready  <= 1'b0;
    end else begin
      if (beat_err) begin
        if (err_count != '1) err_count <= err_count + ERR_W'(1);
        if (!err_seen) begin
          err_seen       <= 1'b1;
          first_err_addr <= addr;
        end
      end

      unique case (state)
        StIdle, StDone: begin
          if (start) begin
            state          <= StWrReq;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            err_seen       <= 1'b0;
            addr           <= ADDR_BASE;
            idx            <= '0;
            axi_if.awvalid <= 1'b1;
            axi_if.awaddr  <= ADDR_BASE;
            axi_if.wvalid  <= 1'b1;
            axi_if.wdata   <= SEED;
            axi_if.wstrb   <= 4'hF;
          end
        end
        StWrReq: begin
          if (aw_hs) begin
            axi_if.awvalid <= 1'b0;
            aw_done        <= 1'b1;
          end
          if (w_hs) begin
            axi_if.wvalid <= 1'b0;
            w_done        <= 1'b1;
          end
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            axi_if.bready <= 1'b1;
            state         <= StWrResp;
          end
        end
        StWrResp: begin
          if (b_hs) begin
            axi_if.bready <= 1'b0;
            if (last) begin
              idx            <= '0;
              addr           <= ADDR_BASE;
              axi_if.arvalid <= 1'b1;
              axi_if.araddr  <= ADDR_BASE;
              state          <= StRdReq;
            end else begin
              idx            <= idx + 32'd1;
              addr           <= addr + 32'd4;
              axi_if.awvalid <= 1'b1;
              axi_if.awaddr  <= addr + 32'd4;
              axi_if.wvalid  <= 1'b1;
              axi_if.wdata   <= lfsr_next(lfsr);
              state          <= StWrReq;
            end
          end
        end
        StRdReq: begin
          if (ar_hs) begin
            axi_if.arvalid <= 1'b0;
            axi_if.rready  <= 1'b1;
            state          <= StRdResp;
          end
        end
        StRdResp: begin
          if (r_hs) begin
            axi_if.rready <= 1'b0;
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0) & ~beat_err;
              state <= StDone;
            end else begin
              idx            <= idx + 32'd1;
              addr           <= addr + 32'd4;
              axi_if.arvalid <= 1'b1;
              axi_if.araddr  <= addr + 32'd4;
              state          <= StRdReq;
            end
          end
        end
        default: state <= StIdle;
      endcase

      // Watchdog overrides whatever the FSM would have done this cycle.
      if (tmo_fire) begin
        aw_done        <= 1'b0;
        w_done         <= 1'b0;
        axi_if.awvalid <= 1'b0;
        axi_if.wvalid  <= 1'b0;
        axi_if.bready  <= 1'b0;
        axi_if.arvalid <= 1'b0;
        axi_if.rready  <= 1'b0;
        busy           <= 1'b0;
        done           <= 1'b1;
        pass           <= 1'b0;
        timeout        <= 1'b1;
        state          <= StDone;
      end
    end
  end

endmodule

// File: tb/tb_axil_mem_tester.sv
// Self-checking bench: a behavioural AXI-Lite slave with fault knobs,
// a monitor logging observed beats, and expected beats queued per run.
module tb_axil_mem_tester;
  import memtest_pkg::*;

  localparam int unsigned NW     = 4;
  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam logic [31:0] SEED_V = 32'hACE1_2468;
  localparam int unsigned EW     = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass, timeout;
  logic [EW-1:0] err_count;
  logic [31:0]   first_err_addr;

  taxi_axil_if axi ();

  axil_mem_tester #(
    .ADDR_BASE  (BASE),
    .NUM_WORDS  (NW),
    .SEED       (SEED_V),
    .ERR_W      (EW),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .axi_if        (axi),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_addr(first_err_addr),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  // Slave fault knobs
  int          cfg_w_delay = 0;
  logic        cfg_corrupt_en = 1'b0;
  logic [31:0] cfg_corrupt_addr = 32'h0;
  logic [1:0]  cfg_bresp = 2'b00;
  logic        cfg_ar_never = 1'b0;

  logic        s_aw_got, s_w_got, s_bvalid, s_rvalid;
  logic [31:0] s_aw_lat, s_w_lat, s_rdata;
  logic [1:0]  s_bresp;
  int          w_wait;
  logic [31:0] mem [0:63];

  logic [31:0] exp_waddr[$], exp_wdata[$], exp_raddr[$];
  logic [31:0] obs_waddr[$], obs_wdata[$], obs_raddr[$];
  int          wb, db, rb;
  int          n_tests = 0;
  int          n_fail = 0;

  assign axi.awready = 1'b1;
  assign axi.wready  = (w_wait >= cfg_w_delay);
  assign axi.arready = ~cfg_ar_never;
  assign axi.bvalid  = s_bvalid;
  assign axi.bresp   = s_bresp;
  assign axi.rvalid  = s_rvalid;
  assign axi.rdata   = s_rdata;
  assign axi.rresp   = RespOkay;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_aw_got <= 1'b0;
      s_w_got  <= 1'b0;
      s_bvalid <= 1'b0;
      s_rvalid <= 1'b0;
      s_aw_lat <= '0;
      s_w_lat  <= '0;
      s_rdata  <= '0;
      s_bresp  <= '0;
      w_wait   <= 0;
    end else begin
      if (axi.wvalid && !axi.wready) w_wait <= w_wait + 1;
      else w_wait <= 0;
      if (axi.awvalid && axi.awready) begin
        s_aw_got <= 1'b1;
        s_aw_lat <= axi.awaddr;
        obs_waddr.push_back(axi.awaddr);
      end
      if (axi.wvalid && axi.wready) begin
        s_w_got <= 1'b1;
        s_w_lat <= axi.wdata;
        obs_wdata.push_back(axi.wdata);
      end
      if (s_aw_got && s_w_got && !s_bvalid) begin
        mem[s_aw_lat[7:2]] <= s_w_lat;
        s_bvalid <= 1'b1;
        s_bresp  <= cfg_bresp;
        s_aw_got <= 1'b0;
        s_w_got  <= 1'b0;
      end
      if (s_bvalid && axi.bready) s_bvalid <= 1'b0;
      if (axi.arvalid && axi.arready) begin
        obs_raddr.push_back(axi.araddr);
        s_rvalid <= 1'b1;
        s_rdata  <= mem[axi.araddr[7:2]] ^
                    {31'b0, cfg_corrupt_en && (axi.araddr == cfg_corrupt_addr)};
      end
      if (s_rvalid && axi.rready) s_rvalid <= 1'b0;
    end
  end

  function automatic logic [31:0] galois(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  task automatic push_expected();
    logic [31:0] s;
    s = SEED_V;
    exp_waddr.delete();
    exp_wdata.delete();
    exp_raddr.delete();
    for (int i = 0; i < NW; i++) begin
      exp_waddr.push_back(BASE + 32'(4 * i));
      exp_wdata.push_back(s);
      exp_raddr.push_back(BASE + 32'(4 * i));
      s = galois(s);
    end
    wb = obs_waddr.size();
    db = obs_wdata.size();
    rb = obs_raddr.size();
  endtask

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, pass, timeout} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_status: got %b required 0000", {busy, done, pass, timeout});
    end
    n_tests++;
    if (err_count !== '0 || first_err_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_err: got cnt=%0d addr=%h required 0/0", err_count, first_err_addr);
    end
    n_tests++;
    if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: got %b required 00000",
               {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready});
    end
    n_tests++;
    if (axi.awaddr !== 32'h0 || axi.wdata !== 32'h0 || axi.araddr !== 32'h0 ||
        axi.wstrb !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_payload: got aw=%h w=%h ar=%h strb=%h required zeros",
               axi.awaddr, axi.wdata, axi.araddr, axi.wstrb);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || axi.awvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start: got busy=%b awvalid=%b required 0/0", busy, axi.awvalid);
    end
  endtask

  task automatic test_clean();
    bit ok;
    push_expected();
    start_run();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_busy: got %b required 1", busy);
    end
    repeat (3) @(negedge clk);
    start = 1'b1;  // must be ignored while busy
    @(negedge clk);
    start = 1'b0;
    wait_done(500, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL clean_done: got timeout waiting required done=1");
    end
    n_tests++;
    if (obs_waddr.size() - wb != NW || obs_wdata.size() - db != NW ||
        obs_raddr.size() - rb != NW) begin
      n_fail++;
      $display("FAIL clean_beats: got aw=%0d w=%0d ar=%0d required %0d each",
               obs_waddr.size() - wb, obs_wdata.size() - db, obs_raddr.size() - rb, NW);
    end
    for (int i = 0; i < NW; i++) begin
      logic [31:0] ea, ed, er, oa, od, orr;
      ea  = exp_waddr.pop_front();
      ed  = exp_wdata.pop_front();
      er  = exp_raddr.pop_front();
      oa  = (wb + i < obs_waddr.size()) ? obs_waddr[wb + i] : 'x;
      od  = (db + i < obs_wdata.size()) ? obs_wdata[db + i] : 'x;
      orr = (rb + i < obs_raddr.size()) ? obs_raddr[rb + i] : 'x;
      n_tests++;
      if (oa !== ea || od !== ed || orr !== er) begin
        n_fail++;
        $display("FAIL clean_beat%0d: got aw=%h w=%h ar=%h required %h %h %h",
                 i, oa, od, orr, ea, ed, er);
      end
    end
    n_tests++;
    if (done !== 1'b1 || pass !== 1'b1 || err_count !== '0 || busy !== 1'b0 ||
        first_err_addr !== 32'h0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_result: got done=%b pass=%b err=%0d busy=%b fea=%h to=%b",
               done, pass, err_count, busy, first_err_addr, timeout);
    end
  endtask

  task automatic test_read_corrupt();
    bit ok;
    cfg_corrupt_en   = 1'b1;
    cfg_corrupt_addr = BASE + 32'h8;
    push_expected();
    start_run();
    wait_done(500, ok);
    n_tests++;
    if (!ok || err_count !== EW'(1) || first_err_addr !== 32'h108 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL corrupt_result: got ok=%b err=%0d fea=%h pass=%b required 1/1/108/0",
               ok, err_count, first_err_addr, pass);
    end
    cfg_corrupt_en = 1'b0;
  endtask

  task automatic test_w_lag();
    bit ok;
    cfg_w_delay = 3;
    push_expected();
    start_run();
    wait_done(800, ok);
    n_tests++;
    if (!ok || obs_waddr.size() - wb != NW || obs_wdata.size() - db != NW) begin
      n_fail++;
      $display("FAIL wlag_beats: got ok=%b aw=%0d w=%0d required 1/%0d/%0d",
               ok, obs_waddr.size() - wb, obs_wdata.size() - db, NW, NW);
    end
    for (int i = 0; i < NW; i++) begin
      logic [31:0] ea, ed, oa, od;
      ea = exp_waddr.pop_front();
      ed = exp_wdata.pop_front();
      oa = (wb + i < obs_waddr.size()) ? obs_waddr[wb + i] : 'x;
      od = (db + i < obs_wdata.size()) ? obs_wdata[db + i] : 'x;
      n_tests++;
      if (oa !== ea || od !== ed) begin
        n_fail++;
        $display("FAIL wlag_beat%0d: got aw=%h w=%h required %h %h", i, oa, od, ea, ed);
      end
    end
    n_tests++;
    if (pass !== 1'b1 || err_count !== '0) begin
      n_fail++;
      $display("FAIL wlag_result: got pass=%b err=%0d required 1/0", pass, err_count);
    end
    cfg_w_delay = 0;
  endtask

  task automatic test_bresp_err();
    bit ok;
    int n;
    cfg_bresp = RespSlverr;
    push_expected();
    start_run();
    n = 0;
    while (!axi.arvalid && n < 500) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (!axi.arvalid || err_count !== EW'(NW)) begin
      n_fail++;
      $display("FAIL bresp_wrphase: got arvalid=%b err=%0d required 1/%0d",
               axi.arvalid, err_count, NW);
    end
    cfg_bresp = RespOkay;
    wait_done(500, ok);
    n_tests++;
    if (!ok || err_count !== EW'(NW) || pass !== 1'b0 || first_err_addr !== BASE) begin
      n_fail++;
      $display("FAIL bresp_result: got ok=%b err=%0d pass=%b fea=%h required 1/%0d/0/%h",
               ok, err_count, pass, first_err_addr, NW, BASE);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    push_expected();
    start_run();
    n = 0;
    while (!axi.rready && n < 500) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (!axi.rready) begin
      n_fail++;
      $display("FAIL midrst_reach: got rready=0 required 1");
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 5'b0 ||
        {busy, done, pass, timeout} !== 4'b0 || err_count !== '0) begin
      n_fail++;
      $display("FAIL midrst_clear: got hs=%b st=%b err=%0d required zeros",
               {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready},
               {busy, done, pass, timeout}, err_count);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_expected();
    start_run();
    wait_done(500, ok);
    n_tests++;
    if (!ok || obs_waddr.size() - wb != NW || obs_raddr.size() - rb != NW) begin
      n_fail++;
      $display("FAIL midrst_beats: got ok=%b aw=%0d ar=%0d required 1/%0d/%0d",
               ok, obs_waddr.size() - wb, obs_raddr.size() - rb, NW, NW);
    end
    for (int i = 0; i < NW; i++) begin
      logic [31:0] ed, er, od, orr;
      ed  = exp_wdata.pop_front();
      er  = exp_raddr.pop_front();
      od  = (db + i < obs_wdata.size()) ? obs_wdata[db + i] : 'x;
      orr = (rb + i < obs_raddr.size()) ? obs_raddr[rb + i] : 'x;
      n_tests++;
      if (od !== ed || orr !== er) begin
        n_fail++;
        $display("FAIL midrst_beat%0d: got w=%h ar=%h required %h %h", i, od, orr, ed, er);
      end
    end
    n_tests++;
    if (pass !== 1'b1 || err_count !== '0) begin
      n_fail++;
      $display("FAIL midrst_result: got pass=%b err=%0d required 1/0", pass, err_count);
    end
  endtask

`ifdef MEMTEST_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    cfg_ar_never = 1'b1;
    push_expected();
    start_run();
    n = 0;
    while (!axi.arvalid && n < 500) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (n != 16) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles required 16", n);
    end
    n_tests++;
    if (timeout !== 1'b1 || done !== 1'b1 || pass !== 1'b0 || axi.arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_state: got to=%b done=%b pass=%b arvalid=%b required 1/1/0/0",
               timeout, done, pass, axi.arvalid);
    end
    cfg_ar_never = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_clean();
    test_read_corrupt();
    test_w_lag();
    test_bresp_err();
    test_reset_mid();
`ifdef MEMTEST_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
